// File: rtl/p32_pkg.sv
// p32 shared configuration: register-file geometry, word and register-address
// types, and the per-cycle port arbitration choice.
// No ports; imported by reg_access_ctrl and p32_wbuf.
package p32_pkg;
  localparam int WORD_W   = 32;
  localparam int RA_W     = 4;
  localparam int NUM_REGS = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RA_W-1:0]   reg_addr_t;

  // What the two register-file ports do this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_t;
endpackage

// File: rtl/p32_wbuf.sv
// In-order writeback queue of {addr, data} entries in front of the register file.
// Latency: a push is visible (count, match) the cycle after it is accepted.
// Backpressure: the caller must not push when count == DEPTH; pop_n must not exceed count.
// Ports: push/push_addr/push_data enqueue; pop_n (0/1/2) retires from the head;
// count, head_* and nxt_* expose the two oldest entries; match_a/match_b flag,
// oldest first, which valid entries hold qa/qb. age_data (oldest first) only
// exists when P32_RA_BYPASS_EN is defined.
module p32_wbuf
  import p32_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  WORD_W = 32,
  parameter int  RA_W   = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [RA_W-1:0]               push_addr,
  input  logic [WORD_W-1:0]             push_data,
  input  logic [1:0]                    pop_n,
  input  logic [RA_W-1:0]               qa,
  input  logic [RA_W-1:0]               qb,
  output logic [CW-1:0]                 count,
  output logic [RA_W-1:0]               head_addr,
  output logic [WORD_W-1:0]             head_data,
  output logic [RA_W-1:0]               nxt_addr,
  output logic [WORD_W-1:0]             nxt_data,
  output logic [DEPTH-1:0]              match_a,
  output logic [DEPTH-1:0]              match_b
`ifdef P32_RA_BYPASS_EN
  ,
  output logic [DEPTH-1:0][WORD_W-1:0]  age_data
`endif
);

  typedef struct packed {
    logic [RA_W-1:0]   addr;
    logic [WORD_W-1:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{addr: push_addr, data: push_data};
        wptr      <= wptr + PW'(1);
      end
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      rptr  <= rptr + PW'(pop_n);
      count <= count + CW'(push) - CW'(pop_n);
    end
  end

  assign head_addr = mem[rptr].addr;
  assign head_data = mem[rptr].data;
  assign nxt_addr  = mem[rptr + PW'(1)].addr;
  assign nxt_data  = mem[rptr + PW'(1)].data;

  // Age-ordered view: bit i refers to the entry i places behind the head.
  always_comb begin
    match_a = '0;
    match_b = '0;
    idx     = '0;
`ifdef P32_RA_BYPASS_EN
    age_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
`ifdef P32_RA_BYPASS_EN
      age_data[i] = mem[idx].data;
`endif
      if (CW'(i) < count) begin
        match_a[i] = (mem[idx].addr == qa);
        match_b[i] = (mem[idx].addr == qb);
      end
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Owns both register-file ports: time-multiplexes operand reads and queued writebacks.
// Latency: read accepted in cycle N returns operands in N+1; writes retire in order, up to two per cycle.
// Backpressure: rd_req_ready=0 while response slot is held, queue is full or a RAW hazard drains; wr_ready=0 when full.
// Ports: rd_req_* (request) / rd_resp_* (registered operand pair), wr_* (writeback),
// rf_* (register-file ports 0 and 1, shared address for read and write).
// Optional build macro P32_RA_BYPASS_EN: forward queued write data into read
// responses instead of stalling on a queued-write address match.
module reg_access_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int WORD_W   = 32,
  parameter int RA_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [RA_W-1:0]   rd_req_ra,
  input  logic [RA_W-1:0]   rd_req_rb,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [WORD_W-1:0] rd_resp_a,
  output logic [WORD_W-1:0] rd_resp_b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [RA_W-1:0]   rf_addr0,
  output logic [WORD_W-1:0] rf_din0,
  output logic              rf_we0,
  input  logic [WORD_W-1:0] rf_dout0,
  output logic [RA_W-1:0]   rf_addr1,
  output logic [WORD_W-1:0] rf_din1,
  output logic              rf_we1,
  input  logic [WORD_W-1:0] rf_dout1
);
  import p32_pkg::*;

  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic [CW-1:0]       wb_count;
  logic [RA_W-1:0]     head_addr;
  logic [RA_W-1:0]     nxt_addr;
  logic [WORD_W-1:0]   head_data;
  logic [WORD_W-1:0]   nxt_data;
  logic [WB_DEPTH-1:0] match_a;
  logic [WB_DEPTH-1:0] match_b;
  logic [1:0]          pop_n;
  logic                full;
  logic                push;
  logic                slot_free;
  logic                hazard_ok;
  logic                dual;
  logic [WORD_W-1:0]   opa;
  logic [WORD_W-1:0]   opb;
  arb_t                arb;
`ifdef P32_RA_BYPASS_EN
  logic [WB_DEPTH-1:0][WORD_W-1:0] age_data;
`endif

  p32_wbuf #(
    .DEPTH  (WB_DEPTH),
    .WORD_W (WORD_W),
    .RA_W   (RA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop_n     (pop_n),
    .qa        (rd_req_ra),
    .qb        (rd_req_rb),
    .count     (wb_count),
    .head_addr (head_addr),
    .head_data (head_data),
    .nxt_addr  (nxt_addr),
    .nxt_data  (nxt_data),
    .match_a   (match_a),
    .match_b   (match_b)
`ifdef P32_RA_BYPASS_EN
    ,
    .age_data  (age_data)
`endif
  );

  assign full      = (wb_count == CW'(WB_DEPTH));
  assign wr_ready  = !full;
  assign push      = wr_valid && !full;
  assign slot_free = !rd_resp_valid || rd_resp_ready;
  // Two writes to one address in one cycle would race on the file; retire singly.
  assign dual      = (wb_count >= CW'(2)) && (nxt_addr != head_addr);

`ifdef P32_RA_BYPASS_EN
  assign hazard_ok = 1'b1;
`else
  assign hazard_ok = !(|match_a) && !(|match_b);
`endif

  // A full queue wins over reads, which bounds how long a read stream can
  // hold off writeback.
  always_comb begin
    if (rst)                                           arb = IDLE;
    else if (full)                                     arb = WRITE;
    else if (rd_req_valid && slot_free && hazard_ok)   arb = READ;
    else if (wb_count != '0)                           arb = WRITE;
    else                                               arb = IDLE;
  end

  always_comb begin
    rf_addr0     = '0;
    rf_addr1     = '0;
    rf_din0      = head_data;
    rf_din1      = nxt_data;
    rf_we0       = 1'b0;
    rf_we1       = 1'b0;
    rd_req_ready = 1'b0;
    pop_n        = 2'd0;
    case (arb)
      READ: begin
        rf_addr0     = rd_req_ra;
        rf_addr1     = rd_req_rb;
        rd_req_ready = 1'b1;
      end
      WRITE: begin
        rf_addr0 = head_addr;
        rf_we0   = 1'b1;
        pop_n    = 2'd1;
        if (dual) begin
          rf_addr1 = nxt_addr;
          rf_we1   = 1'b1;
          pop_n    = 2'd2;
        end
      end
      default: ;
    endcase
  end

  // Newest matching queued write overrides the file value; scanning oldest
  // to newest lets the last hit win.
  always_comb begin
    opa = rf_dout0;
    opb = rf_dout1;
`ifdef P32_RA_BYPASS_EN
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (match_a[i]) opa = age_data[i];
      if (match_b[i]) opb = age_data[i];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_valid <= 1'b0;
      rd_resp_a     <= '0;
      rd_resp_b     <= '0;
    end else if (arb == READ) begin
      rd_resp_valid <= 1'b1;
      rd_resp_a     <= opa;
      rd_resp_b     <= opb;
    end else if (rd_resp_ready) begin
      rd_resp_valid <= 1'b0;
    end
  end

endmodule
